// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler
//   Consumes the fetch cache's two-instruction window, decodes both RV32I
//   words, checks them against a register scoreboard and pairing rules, and
//   issues zero, one or two instructions per cycle into registered slots.
//   After a control-flow instruction issues, all issue stops until execute
//   resolves it or a timeout expires.
// Ports
//   clk, n_rst                  clock, asynchronous active-low reset
//   nothing_filled              window empty this cycle
//   instruction0/instruction1   window words (0 = empty slot)
//   wb0_*/wb1_*                 writeback ports; they clear scoreboard bits
//                               and bypass hazards in the same cycle
//   br_resolved                 outstanding branch/jump resolved (pulse)
//   freeze1/freeze2/dependency_on_ins2  combinational feedback to the cache
//   issue0_*/issue1_*           registered issue slots
//   br_timeout                  1-cycle pulse after a branch wait timed out
//   stall_cycles                saturating count of frozen cycles
module dual_issue_scheduler #(
  parameter int NUM_REGS   = 32,
  parameter int BR_TIMEOUT = 16,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             nothing_filled,
  input  logic [31:0]      instruction0,
  input  logic [31:0]      instruction1,
  input  logic             wb0_en,
  input  logic [4:0]       wb0_rd,
  input  logic             wb1_en,
  input  logic [4:0]       wb1_rd,
  input  logic             br_resolved,
  output logic             freeze1,
  output logic             freeze2,
  output logic             dependency_on_ins2,
  output logic             issue0_valid,
  output logic [31:0]      issue0_instr,
  output logic             issue1_valid,
  output logic [31:0]      issue1_instr,
  output logic             br_timeout,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int CW = (BR_TIMEOUT > 1) ? $clog2(BR_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BR_TIMEOUT - 1);

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       wr;
    logic       mem;
    logic       ctrl;
  } dec_t;

  typedef enum logic {RUN = 1'b0, BR_WAIT = 1'b1} state_e;

  logic [1:0][31:0]    win;
  dec_t [1:0]          dec;
  logic [1:0]          src_busy;
  logic [NUM_REGS-1:0] sb_q, sb_d, wb_clr, busy_v, set_v;
  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic                in_wait, cnt_last, iss0, iss1, hold1;
  logic [1:0]          vld_q;
  logic [1:0][31:0]    instr_q;
  logic                br_timeout_q;
  logic [CNT_W-1:0]    stall_q;

  assign win = {instruction1, instruction0};

  // Decode both window slots; unknown opcodes read and write nothing.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      dec[i]     = '0;
      dec[i].rd  = win[i][11:7];
      dec[i].rs1 = win[i][19:15];
      dec[i].rs2 = win[i][24:20];
      case (win[i][6:0])
        7'b0110011: begin dec[i].use1 = 1'b1; dec[i].use2 = 1'b1; dec[i].wr = 1'b1; end
        7'b0100011: begin dec[i].use1 = 1'b1; dec[i].use2 = 1'b1; dec[i].mem = 1'b1; end
        7'b1100011: begin dec[i].use1 = 1'b1; dec[i].use2 = 1'b1; dec[i].ctrl = 1'b1; end
        7'b0010011: begin dec[i].use1 = 1'b1; dec[i].wr = 1'b1; end
        7'b0000011: begin dec[i].use1 = 1'b1; dec[i].wr = 1'b1; dec[i].mem = 1'b1; end
        7'b1100111: begin dec[i].use1 = 1'b1; dec[i].wr = 1'b1; dec[i].ctrl = 1'b1; end
        7'b0110111,
        7'b0010111: dec[i].wr = 1'b1;
        7'b1101111: begin dec[i].wr = 1'b1; dec[i].ctrl = 1'b1; end
        default: ;
      endcase
      dec[i].wr = dec[i].wr & (dec[i].rd != 5'd0);
    end
  end

  // A writeback landing this cycle hides the busy bit (bypass).
  always_comb begin
    wb_clr = '0;
    if (wb0_en) wb_clr[wb0_rd] = 1'b1;
    if (wb1_en) wb_clr[wb1_rd] = 1'b1;
  end

  assign busy_v = sb_q & ~wb_clr;

  always_comb begin
    for (int i = 0; i < 2; i++)
      src_busy[i] = (dec[i].use1 & busy_v[dec[i].rs1]) |
                    (dec[i].use2 & busy_v[dec[i].rs2]);
  end

  // Slot1 pairing rules: RAW on ins0, WAW, two memory ops, any control flow.
  assign hold1 = src_busy[1] |
                 (dec[0].wr & dec[1].use1 & (dec[1].rs1 == dec[0].rd)) |
                 (dec[0].wr & dec[1].use2 & (dec[1].rs2 == dec[0].rd)) |
                 (dec[0].wr & dec[1].wr & (dec[1].rd == dec[0].rd)) |
                 (dec[0].mem & dec[1].mem) | dec[0].ctrl | dec[1].ctrl;

  // Issue decision; everything is held quiet while reset is asserted.
  always_comb begin
    freeze1            = 1'b0;
    dependency_on_ins2 = 1'b0;
    iss0               = 1'b0;
    iss1               = 1'b0;
    if (n_rst && !in_wait && !nothing_filled && instruction0 != 32'd0) begin
      if (src_busy[0]) begin
        freeze1 = 1'b1;
      end else begin
        iss0 = 1'b1;
        if (instruction1 != 32'd0) begin
          dependency_on_ins2 = hold1;
          iss1               = ~hold1;
        end
      end
    end
  end

  // Scoreboard: a new issue to a register wins over a same-cycle writeback.
  always_comb begin
    set_v = '0;
    if (iss0 && dec[0].wr) set_v[dec[0].rd] = 1'b1;
    if (iss1 && dec[1].wr) set_v[dec[1].rd] = 1'b1;
    sb_d    = busy_v | set_v;
    sb_d[0] = 1'b0;
  end

  // Branch-wait FSM: state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Branch-wait FSM: next state (only slot0 can carry control flow)
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (iss0 && dec[0].ctrl)       state_d = BR_WAIT;
      BR_WAIT: if (br_resolved || cnt_last)   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Branch-wait FSM: outputs
  always_comb begin
    in_wait  = (state_q == BR_WAIT);
    cnt_last = in_wait && (cnt_q == CNT_LAST);
    freeze2  = in_wait & n_rst;
  end

  // Wait counter sits at zero in RUN so every wait starts from zero.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q        <= '0;
      br_timeout_q <= 1'b0;
    end else begin
      cnt_q        <= in_wait ? cnt_q + 1'b1 : '0;
      br_timeout_q <= cnt_last & ~br_resolved;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sb_q    <= '0;
      vld_q   <= '0;
      instr_q <= '0;
      stall_q <= '0;
    end else begin
      sb_q       <= sb_d;
      vld_q      <= {iss1, iss0};
      instr_q[0] <= iss0 ? instruction0 : 32'd0;
      instr_q[1] <= iss1 ? instruction1 : 32'd0;
      if ((freeze1 || freeze2) && stall_q != {CNT_W{1'b1}})
        stall_q <= stall_q + 1'b1;
    end
  end

  assign issue0_valid = vld_q[0];
  assign issue1_valid = vld_q[1];
  assign issue0_instr = instr_q[0];
  assign issue1_instr = instr_q[1];
  assign br_timeout   = br_timeout_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Bench for dual_issue_scheduler: directed window vectors with hand-computed
// literal expectations, plus a register-level behavioural model compared
// against every output on every falling clock edge.
module tb_dual_issue_scheduler;
  localparam int BRT = 16;

  localparam logic [6:0] OP_R = 7'b0110011, OP_S = 7'b0100011, OP_B = 7'b1100011,
                         OP_I = 7'b0010011, OP_L = 7'b0000011, OP_JALR = 7'b1100111,
                         OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;

  logic        clk = 1'b0, n_rst = 1'b0, nf = 1'b1, br = 1'b0;
  logic [31:0] i0 = '0, i1 = '0;
  logic        wb0_en = 1'b0, wb1_en = 1'b0;
  logic [4:0]  wb0_rd = '0, wb1_rd = '0;
  logic        freeze1, freeze2, dep, v0, v1, to;
  logic [31:0] o0, o1, stall;

  dual_issue_scheduler #(.NUM_REGS(32), .BR_TIMEOUT(BRT), .CNT_W(32)) dut (
    .clk(clk), .n_rst(n_rst), .nothing_filled(nf),
    .instruction0(i0), .instruction1(i1),
    .wb0_en(wb0_en), .wb0_rd(wb0_rd), .wb1_en(wb1_en), .wb1_rd(wb1_rd),
    .br_resolved(br), .freeze1(freeze1), .freeze2(freeze2),
    .dependency_on_ins2(dep), .issue0_valid(v0), .issue0_instr(o0),
    .issue1_valid(v1), .issue1_instr(o1), .br_timeout(to), .stall_cycles(stall)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          busy[32];
  bit          m_wait, m_to, m_v0, m_v1;
  int          m_age;
  logic [31:0] m_i0, m_i1, m_stall;
  bit          e_f1, e_f2, e_dep, e_iss0, e_iss1;

  function automatic int dest_of(input logic [31:0] w);
    case (w[6:0])
      OP_R, OP_I, OP_L, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL:
        return (w[11:7] == 5'd0) ? -1 : int'(w[11:7]);
      default: return -1;
    endcase
  endfunction

  function automatic bit reads(input logic [31:0] w, input int r);
    case (w[6:0])
      OP_R, OP_S, OP_B:    return (r == int'(w[19:15])) || (r == int'(w[24:20]));
      OP_I, OP_L, OP_JALR: return r == int'(w[19:15]);
      default:             return 1'b0;
    endcase
  endfunction

  function automatic bit is_mem(input logic [31:0] w);
    return w[6:0] == OP_L || w[6:0] == OP_S;
  endfunction

  function automatic bit is_ctrl(input logic [31:0] w);
    return w[6:0] == OP_B || w[6:0] == OP_JAL || w[6:0] == OP_JALR;
  endfunction

  function automatic bit blocked(input logic [31:0] w);
    for (int r = 1; r < 32; r++)
      if (busy[r] && !(wb0_en && wb0_rd == r) && !(wb1_en && wb1_rd == r) && reads(w, r))
        return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (!n_rst) begin
      foreach (busy[r]) busy[r] = 1'b0;
      m_wait = 0; m_to = 0; m_v0 = 0; m_v1 = 0; m_age = 0;
      m_i0 = '0; m_i1 = '0; m_stall = '0;
      chk("rst_flags", {freeze1, freeze2, dep, v0, v1, to}, 0);
      chk("rst_instr", {o0, o1}, 0);
      chk("rst_stall", stall, 0);
    end else begin
      chk("m_v0", v0, m_v0);
      chk("m_i0", o0, m_i0);
      chk("m_v1", v1, m_v1);
      chk("m_i1", o1, m_i1);
      chk("m_to", to, m_to);
      chk("m_stall", stall, m_stall);
      e_f1 = 0; e_f2 = 0; e_dep = 0; e_iss0 = 0; e_iss1 = 0;
      if (m_wait) e_f2 = 1;
      else if (nf || i0 == 0) ;
      else if (blocked(i0)) e_f1 = 1;
      else begin
        e_iss0 = 1;
        if (i1 != 0) begin
          if (blocked(i1) || (dest_of(i0) >= 0 && reads(i1, dest_of(i0))) ||
              (dest_of(i0) >= 0 && dest_of(i1) == dest_of(i0)) ||
              (is_mem(i0) && is_mem(i1)) || is_ctrl(i0) || is_ctrl(i1))
            e_dep = 1;
          else
            e_iss1 = 1;
        end
      end
      chk("m_freeze1", freeze1, e_f1);
      chk("m_freeze2", freeze2, e_f2);
      chk("m_dep", dep, e_dep);
      // state the DUT will hold after the coming rising edge
      m_v0 = e_iss0; m_i0 = e_iss0 ? i0 : 0;
      m_v1 = e_iss1; m_i1 = e_iss1 ? i1 : 0;
      if (wb0_en) busy[wb0_rd] = 0;
      if (wb1_en) busy[wb1_rd] = 0;
      if (e_iss0 && dest_of(i0) >= 0) busy[dest_of(i0)] = 1;
      if (e_iss1 && dest_of(i1) >= 0) busy[dest_of(i1)] = 1;
      if ((e_f1 || e_f2) && m_stall != 32'hFFFF_FFFF) m_stall++;
      m_to = 0;
      if (m_wait) begin
        if (br) m_wait = 0;
        else if (m_age == BRT - 1) begin m_wait = 0; m_to = 1; end
        else m_age++;
      end else if (e_iss0 && is_ctrl(i0)) begin
        m_wait = 1; m_age = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
    wb0_en = 0; wb1_en = 0; br = 0;
  endtask

  task automatic setw(input logic [31:0] a, input logic [31:0] b);
    nf = 0; i0 = a; i1 = b;
  endtask

  task automatic idle();
    nf = 1; i0 = 0; i1 = 0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [4:0] b);
    wb0_en = 1; wb0_rd = a; wb1_en = 1; wb1_rd = b;
  endtask

  logic [31:0] s;

  initial begin
    // T1: reset with random inputs
    repeat (3) begin
      @(posedge clk); #1;
      nf = 1'($urandom_range(0, 1)); i0 = $urandom; i1 = $urandom;
      wb0_en = 1'($urandom_range(0, 1)); wb0_rd = 5'($urandom);
      wb1_en = 1'($urandom_range(0, 1)); wb1_rd = 5'($urandom);
      br = 1'($urandom_range(0, 1));
    end
    #1 chk("t1_dep", dep, 0);
    chk("t1_freeze1", freeze1, 0);
    @(posedge clk); #1;
    idle(); wb0_en = 0; wb1_en = 0; br = 0; n_rst = 1;
    tick();
    chk("t1_noissue", v0, 0);

    // T2: independent pair issues together
    setw(32'h00500093, 32'h00300193);
    #1 chk("t2_dep", dep, 0);
    tick();
    chk("t2_i0", o0, 32'h00500093);
    chk("t2_i1", o1, 32'h00300193);
    chk("t2_v1", v1, 1);
    setw(32'h00108113, 0);
    #1 chk("t2_sb1", freeze1, 1);
    setw(32'h00018213, 0);
    #1 chk("t2_sb3", freeze1, 1);
    idle(); wb(5'd1, 5'd3);
    tick();

    // T3: RAW inside the window, then freeze until writeback bypass
    setw(32'h00500093, 32'h00108113);
    #1 chk("t3_dep", dep, 1);
    tick();
    chk("t3_i0", o0, 32'h00500093);
    chk("t3_v1", v1, 0);
    setw(32'h00108113, 0);
    #1 chk("t3_freeze_a", freeze1, 1);
    tick();
    s = stall;
    #1 chk("t3_freeze_b", freeze1, 1);
    tick();
    chk("t3_stall", stall, s + 1);
    wb0_en = 1; wb0_rd = 5'd1;
    #1 chk("t3_bypass", freeze1, 0);
    tick();
    chk("t3_issue", o0, 32'h00108113);
    idle(); wb0_en = 1; wb0_rd = 5'd2;
    tick();

    // T4: two memory ops never pair
    setw(32'h00002203, 32'h00002023);
    #1 chk("t4_dep", dep, 1);
    tick();
    chk("t4_i0", o0, 32'h00002203);
    setw(32'h00002023, 0);
    #1 chk("t4_dep2", dep, 0);
    tick();
    chk("t4_sw", o0, 32'h00002023);
    idle(); wb0_en = 1; wb0_rd = 5'd4;
    tick();

    // WAW pair holds slot1; independent R-type + LUI pair issues
    setw(32'h00500093, 32'h00700093);
    #1 chk("waw_dep", dep, 1);
    tick();
    idle(); wb0_en = 1; wb0_rd = 5'd1;
    tick();
    setw(32'h007302B3, 32'h00001437);
    tick();
    chk("pair_i1", o1, 32'h00001437);
    idle(); wb(5'd5, 5'd8);
    tick();

    // br_resolved outside a wait does nothing
    br = 1;
    tick();
    #1 chk("br_idle", freeze2, 0);

    // T5: branch, three frozen cycles, resolved on the third
    setw(32'h00000463, 32'h00300193);
    #1 chk("t5_dep", dep, 1);
    tick();
    chk("t5_beq", o0, 32'h00000463);
    setw(32'h00300193, 0);
    #1 chk("t5_f2_a", freeze2, 1);
    tick();
    #1 chk("t5_f2_b", freeze2, 1);
    tick();
    br = 1;
    #1 chk("t5_f2_c", freeze2, 1);
    tick();
    #1 chk("t5_run", freeze2, 0);
    tick();
    chk("t5_next", o0, 32'h00300193);
    idle(); wb0_en = 1; wb0_rd = 5'd3;
    tick();

    // T6: unresolved branch times out
    setw(32'h00000463, 0);
    tick();
    idle();
    s = stall;
    for (int k = 0; k < BRT; k++) begin
      #1 chk("t6_f2", freeze2, 1);
      tick();
    end
    chk("t6_timeout", to, 1);
    chk("t6_stall", stall, s + BRT);
    #1 chk("t6_run", freeze2, 0);
    tick();
    chk("t6_pulse", to, 0);

    // Reset mid-operation drops in-flight scoreboard entries
    setw(32'h00500093, 0);
    tick();
    #2 n_rst = 0;
    #1 chk("rst_mid_v0", v0, 0);
    @(posedge clk); #1;
    n_rst = 1;
    setw(32'h00108113, 0);
    #1 chk("rst_sb_clear", freeze1, 0);
    tick();
    chk("rst_issue", o0, 32'h00108113);
    idle(); wb0_en = 1; wb0_rd = 5'd2;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
